mouse_position_tracker: RTL and testbench
=========================================

# mouse_position_tracker

Converts decoded PS/2 mouse movement packets into the clamped on-screen pointer position consumed by `displayMouseSprite`, sitting directly upstream of it. Packets are applied to shadow coordinates through a small FSM. The shadow coordinates are published to the sprite stage only at the start of vertical blank, so the pointer never tears within a frame. The block also derives `paletteButtonLocation` and button-edge events from the published state.

## Interface
- `SCREEN_W`, default 1280: visible columns; X clamps to [0, SCREEN_W-1].
- `SCREEN_H`, default 1024: visible rows; Y clamps to [0, SCREEN_H-1].
- `PAL_X0` / `PAL_X1`, defaults 0 / 63: inclusive column range of the palette button.
- `PAL_Y0` / `PAL_Y1`, defaults 0 / 31: inclusive row range of the palette button.
- `clk108MHz`  in  1  pixel clock. One clock domain only; reset is asynchronous and active-low.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pktValid`  in  1  packet present.
- `pktReady`  out  1  block can accept a packet.
- `pktDx`  in  9  signed two's-complement X delta; positive is right.
- `pktDy`  in  9  signed Y delta; positive is up (PS/2 convention).
- `pktXOvf`, `pktYOvf`  in  1 each  per-axis overflow flags.
- `pktButtons`  in  3  {middle, right, left}.
- `vidClmn`, `vidRow`  in  11 each  current raster position from the timing generator.
- `mouseColumn`  out  11  published X.
- `mouseRow`  out  10  published Y.
- `paletteButtonLocation`  out  1  published pointer is inside the palette rectangle.
- `mouseButtons`  out  3  published button state.
- `leftClick`  out  1  one-cycle pulse on a left-button rising edge.

## Operation
- FSM states (from `mouse_pkg`): `IDLE`, `UPD_X`, `UPD_Y`. Reset state is `IDLE`.
- `pktReady` = (state == `IDLE`), decoded combinationally. Accept when `pktValid & pktReady`: capture all packet fields and go to `UPD_X`.
- `UPD_X`:
  - `workX` = clamp(`shadowX` + sext12(`pktDx`)), computed at 12-bit signed width.
  - If `pktXOvf` is set, use delta 0.
  - Go to `UPD_Y`.
- `UPD_Y`:
  - newY = clamp(`shadowY` − sext12(`pktDy`)); if `pktYOvf` is set, newY = `shadowY`.
  - Atomically write `shadowX` ← `workX`, `shadowY` ← newY, `shadowBtn` ← captured buttons.
  - If captured left = 1 and the previous `shadowBtn[0]` = 0, set the pending-click flag.
  - Go to `IDLE`.
- Clamp rule: result < 0 becomes 0; result > max becomes max.
- Frame tick = (`vidRow` == `SCREEN_H`) && (`vidClmn` == 0). On the tick:
  - `mouseColumn` ← `shadowX`, `mouseRow` ← `shadowY[9:0]`, `mouseButtons` ← `shadowBtn`.
  - If the pending-click flag is set, `leftClick` pulses and the flag clears.
- `paletteButtonLocation` is registered from the published `mouseColumn`/`mouseRow` against the inclusive `PAL_*` bounds.
- Reset values:
  - `shadowX` = `mouseColumn` = 640; `shadowY` = `mouseRow` = 512.
  - Buttons 0, `leftClick` 0, pending flag 0.
  - `paletteButtonLocation` 0; `pktReady` 1.
- Reset asserted mid-packet aborts the packet. The shadow state reverts to reset values and the packet is not applied.

## Timing
- Packet accepted at edge T. Shadow update lands at edge T+2. `pktReady` is high again in cycle T+2.
- Peak throughput: one packet per 3 cycles.
- Shadow-to-published latency: the first frame tick at or after the shadow update.
  - A shadow write and a frame tick on the same edge: the tick publishes the old shadow value.
  - The new value publishes at the next frame tick, one frame later.
- `paletteButtonLocation` trails a published position change by 1 cycle.
- `leftClick` is high for exactly the one cycle following the tick edge.
- Packets arriving while busy are held by the upstream block; they are never dropped.

## Structure
- `mouse_pkg` contains:
  - `SCREEN_W_DEF`, `SCREEN_H_DEF`, `HOME_X` = 640, `HOME_Y` = 512.
  - The `mouse_state_t` enum (`IDLE`, `UPD_X`, `UPD_Y`).
  - The 12-bit signed coordinate typedef.
- Sub-module `mouse_axis_clamp`: combinational sign-extend, add, and clamp. Parameter MAX; inputs pos, delta, ovf. One instance per axis.

## Test plan
- Reset with no packets, 2 frame ticks -> `mouseColumn` = 640, `mouseRow` = 512, `paletteButtonLocation` = 0, `leftClick` never high.
- dx = +10, dy = +5, then tick -> column 650, row 507. No change before the tick.
- Pointer at (1275, 1020); dx = +20, dy = −9 -> (1279, 1023). Then dx = −256 repeated 6× -> column 0.
- `pktXOvf` = 1, dx = +100, dy = +1 -> column unchanged, row −1.
- `pktValid` held for 4 back-to-back packets -> `pktReady` pattern 1,0,0 per packet; all 4 packets applied in order.
- Shadow write on the same edge as the tick -> old value published; new value publishes one frame later.
- Move to (10, 10) -> `paletteButtonLocation` = 1 one cycle after the tick.
- Left button 0→1 -> a single `leftClick` pulse at that tick.

Source files
------------

// File: rtl/mouse_position_tracker_pkg.sv
// Shared types and constants for the mouse pointer tracking path.
// The package name matches the name the surrounding codebase already imports.
package mouse_pkg;

    localparam int SCREEN_W_DEF = 1280;
    localparam int SCREEN_H_DEF = 1024;
    localparam int HOME_X       = 640;
    localparam int HOME_Y       = 512;

    typedef enum logic [1:0] {
        IDLE,
        UPD_X,
        UPD_Y
    } mouse_state_t;

    // Wide enough to hold any screen coordinate plus a full 9-bit delta without wrapping.
    typedef logic signed [11:0] coord_t;

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Valid/ready packet channel carrying decoded PS/2 movement packets.
// The decoder is the master and the tracker is the slave.
interface mouse_position_tracker_if;

    logic              pktValid;
    logic              pktReady;
    logic signed [8:0] pktDx;
    logic signed [8:0] pktDy;
    logic              pktXOvf;
    logic              pktYOvf;
    logic [2:0]        pktButtons;

    modport master (
        output pktValid, pktDx, pktDy, pktXOvf, pktYOvf, pktButtons,
        input  pktReady
    );

    modport slave (
        input  pktValid, pktDx, pktDy, pktXOvf, pktYOvf, pktButtons,
        output pktReady
    );

endinterface

// File: rtl/mouse_position_tracker_axis_clamp.sv
// One pointer axis: sign-extend the packet delta, add it to the position, saturate to [0, MAX].
// NEGATE flips the delta so PS/2 "up is positive" maps onto raster rows growing downward.
module mouse_axis_clamp
    import mouse_pkg::*;
#(
    parameter int MAX    = SCREEN_W_DEF - 1,
    parameter bit NEGATE = 1'b0
) (
    input  coord_t            pos,
    input  logic signed [8:0] delta,
    input  logic              ovf,
    output coord_t            result
);

    function automatic coord_t sat(input coord_t v);
        if (v < 0)
            return '0;
        else if (v > coord_t'(MAX))
            return coord_t'(MAX);
        else
            return v;
    endfunction

    coord_t d_ext;
    coord_t d_eff;

    assign d_ext = {{3{delta[8]}}, delta};

    // An overflowed axis carries a meaningless delta, so it contributes no motion.
    always_comb begin
        d_eff  = '0;
        if (!ovf)
            d_eff = NEGATE ? -d_ext : d_ext;
        result = sat(pos + d_eff);
    end

endmodule

// File: rtl/mouse_position_tracker.sv
// Applies PS/2 packets to shadow pointer coordinates and republishes them once per frame
// at the start of vertical blank, so the sprite stage never sees a mid-frame move.
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int PAL_X0   = 0,
    parameter int PAL_X1   = 63,
    parameter int PAL_Y0   = 0,
    parameter int PAL_Y1   = 31
) (
    input  logic                     clk108MHz,
    input  logic                     reset_n,
    mouse_position_tracker_if.slave  pkt,
    input  logic [10:0]              vidClmn,
    input  logic [10:0]              vidRow,
    output logic [10:0]              mouseColumn,
    output logic [9:0]               mouseRow,
    output logic                     paletteButtonLocation,
    output logic [2:0]               mouseButtons,
    output logic                     leftClick
);

    localparam logic [10:0] TICK_ROW = 11'(SCREEN_H);

    mouse_state_t      state_q, state_d;
    logic              accept, ld_x, ld_y;

    logic signed [8:0] cap_dx, cap_dy;
    logic              cap_xovf, cap_yovf;
    logic [2:0]        cap_btn;

    coord_t            shadow_x, shadow_y, work_x, next_x, next_y;
    logic [2:0]        shadow_btn;
    logic              click_pend;
    logic              frame_tick;
    logic              in_pal;
    int                col_i, row_i;
    logic              unused_bits;

    assign frame_tick = (vidRow == TICK_ROW) && (vidClmn == '0);

    always_ff @(posedge clk108MHz or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pkt.pktValid) state_d = UPD_X;
            UPD_X:   state_d = UPD_Y;
            UPD_Y:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt.pktReady = (state_q == IDLE);
        accept       = pkt.pktValid && (state_q == IDLE);
        ld_x         = (state_q == UPD_X);
        ld_y         = (state_q == UPD_Y);
    end

    // Packet fields are only consumed while the FSM is busy, so they need no reset.
    always_ff @(posedge clk108MHz) begin
        if (accept) begin
            cap_dx   <= pkt.pktDx;
            cap_dy   <= pkt.pktDy;
            cap_xovf <= pkt.pktXOvf;
            cap_yovf <= pkt.pktYOvf;
            cap_btn  <= pkt.pktButtons;
        end
        if (ld_x)
            work_x <= next_x;
    end

    mouse_axis_clamp #(.MAX(SCREEN_W - 1), .NEGATE(1'b0)) u_clamp_x (
        .pos    (shadow_x),
        .delta  (cap_dx),
        .ovf    (cap_xovf),
        .result (next_x)
    );

    mouse_axis_clamp #(.MAX(SCREEN_H - 1), .NEGATE(1'b1)) u_clamp_y (
        .pos    (shadow_y),
        .delta  (cap_dy),
        .ovf    (cap_yovf),
        .result (next_y)
    );

    // X, Y and buttons commit together so a frame tick never sees half a packet.
    always_ff @(posedge clk108MHz or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x   <= coord_t'(HOME_X);
            shadow_y   <= coord_t'(HOME_Y);
            shadow_btn <= '0;
            click_pend <= 1'b0;
        end else begin
            if (ld_y) begin
                shadow_x   <= work_x;
                shadow_y   <= next_y;
                shadow_btn <= cap_btn;
            end
            // A click landing on the tick edge belongs to the next frame, so setting wins.
            if (ld_y && cap_btn[0] && !shadow_btn[0])
                click_pend <= 1'b1;
            else if (frame_tick)
                click_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk108MHz or negedge reset_n) begin
        if (!reset_n) begin
            mouseColumn           <= 11'(HOME_X);
            mouseRow              <= 10'(HOME_Y);
            mouseButtons          <= '0;
            leftClick             <= 1'b0;
            paletteButtonLocation <= 1'b0;
        end else begin
            if (frame_tick) begin
                mouseColumn  <= shadow_x[10:0];
                mouseRow     <= shadow_y[9:0];
                mouseButtons <= shadow_btn;
            end
            leftClick             <= frame_tick && click_pend;
            paletteButtonLocation <= in_pal;
        end
    end

    assign col_i  = int'(mouseColumn);
    assign row_i  = int'(mouseRow);
    assign in_pal = (col_i >= PAL_X0) && (col_i <= PAL_X1) &&
                    (row_i >= PAL_Y0) && (row_i <= PAL_Y1);

    // Clamping keeps these bits zero; they exist only as arithmetic headroom.
    assign unused_bits = ^{shadow_x[11], shadow_y[11:10]};

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker: packet application, clamping, frame-tick
// publication, palette hit detection, click pulses and mid-packet reset.
module tb_mouse_position_tracker;
    import mouse_pkg::*;

    localparam int SH = 1024;

    logic        clk108MHz = 1'b0;
    logic        reset_n   = 1'b0;
    logic [10:0] vidClmn, vidRow;
    logic [10:0] mouseColumn;
    logic [9:0]  mouseRow;
    logic        paletteButtonLocation;
    logic [2:0]  mouseButtons;
    logic        leftClick;

    int total  = 0;
    int bad    = 0;
    int lc_cnt = 0;

    mouse_position_tracker_if pif();

    mouse_position_tracker dut (
        .clk108MHz             (clk108MHz),
        .reset_n               (reset_n),
        .pkt                   (pif),
        .vidClmn               (vidClmn),
        .vidRow                (vidRow),
        .mouseColumn           (mouseColumn),
        .mouseRow              (mouseRow),
        .paletteButtonLocation (paletteButtonLocation),
        .mouseButtons          (mouseButtons),
        .leftClick             (leftClick)
    );

    always #5 clk108MHz = ~clk108MHz;

    always @(negedge clk108MHz) if (leftClick) lc_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk108MHz);
        #1;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, "_col"}, 32'(mouseColumn), x);
        chk({tag, "_row"}, 32'(mouseRow), y);
    endtask

    task automatic drive(input int dx, input int dy, input logic xo, input logic yo,
                         input logic [2:0] b);
        pif.pktDx      = 9'(dx);
        pif.pktDy      = 9'(dy);
        pif.pktXOvf    = xo;
        pif.pktYOvf    = yo;
        pif.pktButtons = b;
    endtask

    task automatic send(input int dx, input int dy, input logic xo, input logic yo,
                        input logic [2:0] b);
        int n;
        n = 0;
        while (!pif.pktReady && n < 10) begin
            step();
            n++;
        end
        if (!pif.pktReady) chk("ready_timeout", 32'(pif.pktReady), 1);
        drive(dx, dy, xo, yo, b);
        pif.pktValid = 1'b1;
        step();
        pif.pktValid = 1'b0;
        step();
        step();
    endtask

    task automatic tick();
        vidRow  = 11'(SH);
        vidClmn = '0;
        step();
        vidRow  = '0;
        vidClmn = 11'd5;
    endtask

    initial begin
        vidRow  = '0;
        vidClmn = 11'd5;
        pif.pktValid = 1'b0;
        drive(0, 0, 1'b0, 1'b0, 3'b000);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state and idle frames
        chk_pos("rst", 640, 512);
        chk("rst_pal", 32'(paletteButtonLocation), 0);
        chk("rst_btn", 32'(mouseButtons), 0);
        chk("rst_ready", 32'(pif.pktReady), 1);
        tick();
        tick();
        step();
        chk_pos("idle_ticks", 640, 512);
        chk("idle_pal", 32'(paletteButtonLocation), 0);
        chk("idle_clicks", 32'(lc_cnt), 0);

        // Basic move, held back until the tick
        send(10, 5, 1'b0, 1'b0, 3'b000);
        chk_pos("pre_tick", 640, 512);
        tick();
        chk_pos("move1", 650, 507);

        // Walk to (1275,1020), then saturate at the lower-right corner
        send(255, -256, 1'b0, 1'b0, 3'b000);
        send(255, -256, 1'b0, 1'b0, 3'b000);
        send(115, -1, 1'b0, 1'b0, 3'b000);
        tick();
        chk_pos("near_corner", 1275, 1020);
        send(20, -9, 1'b0, 1'b0, 3'b000);
        tick();
        chk_pos("clamp_max", 1279, 1023);
        repeat (6) send(-256, 0, 1'b0, 1'b0, 3'b000);
        tick();
        chk_pos("clamp_zero", 0, 1023);

        // X overflow suppresses X only
        send(100, 1, 1'b1, 1'b0, 3'b000);
        tick();
        chk_pos("xovf", 0, 1022);

        // Four back-to-back packets; result depends on application order
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("b2b_ready%0d", i), 32'(pif.pktReady), (i % 3 == 0) ? 1 : 0);
            case (i / 3)
                0: drive(-5, 255, 1'b0, 1'b0, 3'b000);
                1: drive(10, -255, 1'b0, 1'b0, 3'b000);
                2: drive(-20, -10, 1'b0, 1'b0, 3'b000);
                default: drive(7, 23, 1'b0, 1'b0, 3'b000);
            endcase
            pif.pktValid = 1'b1;
            step();
        end
        pif.pktValid = 1'b0;
        tick();
        chk_pos("b2b", 7, 1000);

        // Shadow write coinciding with a tick publishes the old value
        drive(3, 255, 1'b0, 1'b0, 3'b000);
        pif.pktValid = 1'b1;
        step();
        pif.pktValid = 1'b0;
        step();
        tick();
        chk_pos("same_edge_old", 7, 1000);
        tick();
        chk_pos("same_edge_new", 10, 745);

        // Into the palette rectangle
        send(0, 255, 1'b0, 1'b0, 3'b000);
        send(0, 255, 1'b0, 1'b0, 3'b000);
        send(0, 225, 1'b0, 1'b0, 3'b000);
        tick();
        chk_pos("pal_pos", 10, 10);
        chk("pal_at_tick", 32'(paletteButtonLocation), 0);
        step();
        chk("pal_after", 32'(paletteButtonLocation), 1);

        // Left button press produces a single pulse at the tick
        send(0, 0, 1'b0, 1'b0, 3'b001);
        chk("click_pre", 32'(leftClick), 0);
        tick();
        chk("click_pulse", 32'(leftClick), 1);
        chk("click_btn", 32'(mouseButtons), 1);
        step();
        chk("click_end", 32'(leftClick), 0);
        send(0, 0, 1'b0, 1'b0, 3'b001);
        tick();
        chk("click_held", 32'(leftClick), 0);
        step();
        chk("click_count", 32'(lc_cnt), 1);

        // Reset in the middle of a packet aborts it
        drive(50, 0, 1'b0, 1'b0, 3'b000);
        pif.pktValid = 1'b1;
        step();
        pif.pktValid = 1'b0;
        step();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        chk("abort_ready", 32'(pif.pktReady), 1);
        chk("abort_btn", 32'(mouseButtons), 0);
        step();
        step();
        tick();
        chk_pos("abort", 640, 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
